// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel datapath: pixel and window widths, the
// tap index mapping used by both the window generator and the PE array
// wiring, and a helper that sizes position counters from image dimensions.
package sobel_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_TAPS = 9;
    localparam int WIN_W    = PIX_W * WIN_TAPS;

    typedef logic [PIX_W-1:0] pix_t;

    // One freshly assembled window column: rows r-2, r-1 and r.
    typedef struct packed {
        pix_t top;
        pix_t mid;
        pix_t bot;
    } win_col_t;

    // Flattened tap position of p[r][c]; r=0 is the top row, c=0 the left column.
    function automatic int idx(input int r, input int c);
        return 3 * r + c;
    endfunction

    // Counter width able to hold 0..n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_line_mem.sv
// One image line of storage: single write port, asynchronous read on the
// same address. Read returns the old contents during a write cycle, so the
// caller sees the previous row's pixel at that column.
//
// Ports:
//   clk      clock
//   we_i     write enable
//   addr_i   column address (shared by read and write)
//   wdata_i  pixel to store
//   rdata_o  pixel currently stored at addr_i
module sobel_line_mem
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  pix_t          wdata_i,
    output pix_t          rdata_o
);

    // Contents are never reset: every column is rewritten before it is read
    // back for a window.
    pix_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-order pixel stream to 3x3 neighbourhood generator for the Sobel
// PE chains. Two line memories hold the previous two rows; a 3x3 register
// window shifts left on every accepted pixel. One window is emitted per
// interior pixel (no border padding), so a W x H frame yields (W-2)*(H-2)
// windows, the last one flagged with win_eof.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   pix_valid  input pixel present
//   pix_ready  block can take a pixel this cycle (combinational)
//   pix_data   unsigned 8-bit pixel
//   pix_sof    pixel is (0,0) of a new frame
//   win_valid  win_data holds a window
//   win_ready  downstream takes the window
//   win_data   p[r][c] at bits [8*(3r+c) +: 8], r=0 top, c=0 left
//   win_eof    window is the last of its frame
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_sof,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [WIN_W-1:0] win_data,
    output logic             win_eof
);

    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int ROW_W = cnt_w(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic             valid_q, valid_d;
    logic             eof_q, eof_d;
    logic             accept;
    logic             last_col, last_row;
    pix_t             tap_q [3][3];
    pix_t             lb0_rd, lb1_rd;
    win_col_t         new_col;

    // Single output stage: stall only while a window is held and not taken.
    assign pix_ready = !valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;

    // sof forces the current pixel to (0,0), which also abandons any
    // partially received frame.
    assign cur_col  = pix_sof ? '0 : col_q;
    assign cur_row  = pix_sof ? '0 : row_q;
    assign last_col = (cur_col == COL_LAST);
    assign last_row = (cur_row == ROW_LAST);

    // lb0 carries row-1, lb1 carries row-2. Both are read at the current
    // column before the write lands, then lb0's old pixel moves into lb1.
    sobel_line_mem #(
        .DEPTH (IMG_WIDTH),
        .AW    (COL_W)
    ) u_lb0 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (cur_col),
        .wdata_i (pix_data),
        .rdata_o (lb0_rd)
    );

    sobel_line_mem #(
        .DEPTH (IMG_WIDTH),
        .AW    (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (cur_col),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    always_comb begin
        new_col.top = lb1_rd;
        new_col.mid = lb0_rd;
        new_col.bot = pix_data;
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q;
        eof_d   = eof_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
            // Rows 0/1 have no full neighbourhood yet; cols 0/1 hold stale
            // columns carried over from the previous row.
            valid_d = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            eof_d   = last_row && last_col;
        end else if (win_ready) begin
            valid_d = 1'b0;
            eof_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    tap_q[r][c] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    tap_q[r][0] <= tap_q[r][1];
                    tap_q[r][1] <= tap_q[r][2];
                end
                tap_q[0][2] <= new_col.top;
                tap_q[1][2] <= new_col.mid;
                tap_q[2][2] <= new_col.bot;
            end
        end
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        for (genvar gc = 0; gc < 3; gc++) begin : g_col
            assign win_data[PIX_W*idx(gr, gc) +: PIX_W] = tap_q[gr][gc];
        end
    end

    assign win_valid = valid_q;
    assign win_eof   = eof_q;

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Upstream feeder for the Sobel PE chains: takes a raster-order 8-bit pixel stream and produces one complete 3x3 neighbourhood per interior pixel.
- Holds the previous two image rows in internal line memories and keeps a 3x3 shift window.
- Presents each window with a valid/ready handshake to the Gx/Gy PE columns, which consume unsigned 8-bit taps.
- Border pixels are not padded: a W x H frame yields exactly (W-2)*(H-2) windows.

Parameters:
- IMG_WIDTH, 640, pixels per row; legal range 3..4096.
- IMG_HEIGHT, 480, rows per frame; legal range 3..4096.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pix_valid  in  1  pixel present on pix_data.
- pix_ready  out  1  block can accept a pixel this cycle.
- pix_data  in  8  unsigned pixel.
- pix_sof  in  1  qualifies pix_data as pixel (0,0) of a new frame.
- win_valid  out  1  win_data holds a valid window.
- win_ready  in  1  downstream accepts the window.
- win_data  out  72  3x3 window. Tap p[r][c] sits at bits [8*(3r+c)+7 : 8*(3r+c)]. r=0 is the oldest row (top); c=0 is the oldest column (left).
- win_eof  out  1  qualifies win_data as the last window of the frame.

Behaviour:
- Accept: a pixel is accepted when pix_valid && pix_ready. No state changes on non-accept cycles.
- Ready: pix_ready = !win_valid || win_ready, combinational. Single output stage; the block stalls only when a window is held and not taken.
- Counters: col (0..W-1) and row (0..H-1) are the position of the pixel being accepted.
  - If pix_sof is set on an accept, that pixel is treated as (0,0) regardless of the counter values.
  - After each accept, col increments. At W-1 it wraps to 0 and row increments.
  - At (H-1, W-1) both counters wrap to 0, so back-to-back frames work without sof.
- Line memories: lb0 holds row-1 and lb1 holds row-2, each of depth IMG_WIDTH x 8.
  - On accept at column col, reads are taken before writes (old contents): top = lb1[col], mid = lb0[col], bot = pix_data.
  - Same edge: lb1[col] <= lb0[col] and lb0[col] <= pix_data.
- Window shift: on accept, columns 0 <- 1 <- 2 and the new column 2 = {top, mid, bot}. win_data is driven directly from these registers.
- Valid:
  - On accept at (row, col), the next-cycle win_valid = (row >= 2 && col >= 2).
  - Otherwise, win_valid clears when win_ready is set; if win_valid && !win_ready, it holds.
  - Latency is 1 cycle from accept of pixel (r,c) to the window centred at (r-1, c-1).
- win_eof: registered with win_valid; set when the accepted pixel is (H-1, W-1).
- Hold stability: while win_valid && !win_ready, win_data and win_eof do not change (no accepts occur).
- Mid-row column wrap: the window registers carry stale columns from the previous row into col 0/1. These windows are suppressed by the col >= 2 rule.
- Row gating:
  - Rows 0 and 1 of each frame never emit windows.
  - Both lines are fully rewritten before row 2 reads them, so stale data from an aborted frame cannot leak.
- Reset values:
  - Outputs: win_valid=0, win_eof=0, win_data=0.
  - Internal: row=0, col=0.
  - Line memories are not reset and their contents are don't-care.
  - Reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- Early sof: an sof arriving mid-frame also abandons the frame. A window pending at the output is still delivered normally.

Decomposition:
- Shared sobel package:
  - PIX_W=8 and WIN_TAPS=9.
  - Tap index function idx(r,c)=3r+c, shared with the PE array wiring.
  - Counter width as $clog2 of the dimension parameters.
- One natural sub-module, sobel_line_mem: a single-port-write, async-read register array of depth IMG_WIDTH x 8. It is instantiated twice (lb0 and lb1).

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*16+col, sof on first pixel):
1. Continuous stream, win_ready=1.
   - Exactly 6 windows are produced.
   - The first window appears 1 cycle after accepting pixel (2,2) and has p00..p22 = 00,01,02,10,11,12,20,21,22 (hex).
   - The last window has p22=0x34 with win_eof=1.
2. Window placement: no window follows pixels in rows 0-1 or at cols 0-1, and each window's p11 equals (r-1)*16+(c-1).
3. Backpressure: hold win_ready=0 for 5 cycles after the first window.
   - pix_ready=0 throughout.
   - win_data stays at the first window.
   - The stream resumes with no loss or duplication (6 windows total).
4. Two frames back-to-back without a second sof: the second frame's windows equal the first's, and the first window of frame 2 appears only after its pixel (2,2).
5. Abort via sof at frame 1 pixel (2,3), then restart with a full frame.
   - Only one window is produced before the abort.
   - The new frame produces the same 6 windows as scenario 1.
6. Assert rst_n low mid-row 3 while win_valid=1.
   - win_valid and win_eof drop immediately (asynchronous).
   - After release, a full frame reproduces scenario 1.
